// File: rtl/e203_ifu_mt_pkg.sv
// Shared definitions for the multi-thread IFU pre-decode path: opcodes, TTIO codes and
// the packed decoded-entry layout.
package e203_ifu_mt_pkg;

  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;

  localparam logic [2:0] F3_TTIAT = 3'b000;
  localparam logic [2:0] F3_TTOAT = 3'b001;

  typedef struct packed {
    logic       rv32;
    logic       bjp;
    logic       jal;
    logic       jalr;
    logic       bxx;
    logic       rs1en;
    logic       rs2en;
    logic [4:0] rs1idx;
    logic [4:0] rs2idx;
    logic       prdt_taken;
    logic       ttiat;
    logic       ttoat;
  } dec_t;

  localparam int unsigned DEC_W = $bits(dec_t);

endpackage

// File: rtl/e203_ifu_mt_predec.sv
// Combinational mini-decoder: one fetched instruction (RV32 or RVC) to a decoded entry plus
// its sign-extended branch/jump offset.
module e203_ifu_mt_predec
  import e203_ifu_mt_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  output dec_t            dec,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [2:0]  cf3;

  always_comb begin
    dec   = '0;
    imm32 = '0;
    opc   = instr[6:0];
    f3    = instr[14:12];
    cf3   = instr[15:13];
    if (instr[1:0] == 2'b11) begin
      dec.rv32   = 1'b1;
      dec.rs1idx = instr[19:15];
      dec.rs2idx = instr[24:20];
      case (opc)
        OPC_JAL: begin
          dec.jal = 1'b1;
          imm32   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        end
        OPC_JALR: begin
          dec.jalr  = 1'b1;
          dec.rs1en = 1'b1;
          imm32     = {{20{instr[31]}}, instr[31:20]};
        end
        OPC_BRANCH: begin
          dec.bxx   = 1'b1;
          dec.rs1en = 1'b1;
          dec.rs2en = 1'b1;
          imm32     = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        end
        OPC_CUSTOM0: begin
          if (f3 == F3_TTIAT) begin
            dec.ttiat = 1'b1;
            dec.rs1en = 1'b1;
          end else if (f3 == F3_TTOAT) begin
            dec.ttoat = 1'b1;
            dec.rs1en = 1'b1;
          end
        end
        default: ;
      endcase
    end else if (instr[1:0] == 2'b01) begin
      if (cf3 == 3'b101 || cf3 == 3'b001) begin
        dec.jal = 1'b1;
        imm32   = {{20{instr[12]}}, instr[12], instr[8], instr[10:9], instr[6], instr[7],
                   instr[2], instr[11], instr[5:3], 1'b0};
      end else if (cf3 == 3'b110 || cf3 == 3'b111) begin
        dec.bxx    = 1'b1;
        dec.rs1en  = 1'b1;
        dec.rs1idx = {2'b01, instr[9:7]};
        imm32      = {{23{instr[12]}}, instr[12], instr[6:5], instr[2], instr[11:10],
                      instr[4:3], 1'b0};
      end
    end else if (instr[1:0] == 2'b10 && cf3 == 3'b100 && instr[6:2] == 5'd0 &&
                 instr[11:7] != 5'd0) begin
      // C.JR / C.JALR: target is rs1 with zero offset
      dec.jalr   = 1'b1;
      dec.rs1en  = 1'b1;
      dec.rs1idx = instr[11:7];
    end
    dec.bjp = dec.jal | dec.jalr | dec.bxx;
    for (int i = 0; i < int'(XLEN); i++) begin
      imm[i] = (i < 32) ? imm32[i] : imm32[31];
    end
    // Static backward-taken: jumps always, branches when the offset is negative
    dec.prdt_taken = dec.jal | dec.jalr | (dec.bxx & imm32[31]);
  end

endmodule

// File: rtl/e203_ifu_mt_predec_buf.sv
// Multi-thread pre-decode buffer: per-thread FIFOs of decoded entries behind a locking
// round-robin arbiter, with per-thread flush.
module e203_ifu_mt_predec_buf
  import e203_ifu_mt_pkg::*;
#(
  parameter int unsigned NTHREADS = 4,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned PC_SIZE  = 32,
  parameter int unsigned XLEN     = 32,
  localparam int unsigned TID_W   = $clog2(NTHREADS),
  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_valid,
  output logic                      i_ready,
  input  logic [31:0]               i_instr,
  input  logic [PC_SIZE-1:0]        i_pc,
  input  logic [TID_W-1:0]          i_tid,
  input  logic [NTHREADS-1:0]       flush,
  output logic                      o_valid,
  input  logic                      o_ready,
  output logic [TID_W-1:0]          o_tid,
  output logic [PC_SIZE-1:0]        o_pc,
  output logic [31:0]               o_instr,
  output logic                      o_rv32,
  output logic                      o_bjp,
  output logic                      o_jal,
  output logic                      o_jalr,
  output logic                      o_bxx,
  output logic                      o_rs1en,
  output logic                      o_rs2en,
  output logic [4:0]                o_rs1idx,
  output logic [4:0]                o_rs2idx,
  output logic [XLEN-1:0]           o_bjp_imm,
  output logic                      o_prdt_taken,
  output logic                      o_ttiat,
  output logic                      o_ttoat,
  output logic [NTHREADS*CNT_W-1:0] o_cnt
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned ENT_W = PC_SIZE + 32 + DEC_W + XLEN;

  logic [CNT_W-1:0] cnt_q  [NTHREADS];
  logic [CNT_W-1:0] cnt_d  [NTHREADS];
  logic [AW-1:0]    wptr_q [NTHREADS];
  logic [AW-1:0]    wptr_d [NTHREADS];
  logic [AW-1:0]    rptr_q [NTHREADS];
  logic [AW-1:0]    rptr_d [NTHREADS];
  logic [ENT_W-1:0] mem_q  [NTHREADS][DEPTH];

  logic [TID_W-1:0]    last_q, last_d;
  logic                lock_q, lock_d;
  logic [TID_W-1:0]    lock_tid_q, lock_tid_d;
  logic [NTHREADS-1:0] avail;
  logic                gnt_valid;
  logic [TID_W-1:0]    gnt;
  int unsigned         idx;
  logic                push, pop;

  dec_t             in_dec, out_dec;
  logic [XLEN-1:0]  in_imm;
  logic [ENT_W-1:0] in_ent, out_ent;

  e203_ifu_mt_predec #(
    .XLEN(XLEN)
  ) u_predec (
    .instr(i_instr),
    .dec  (in_dec),
    .imm  (in_imm)
  );

  assign in_ent = {i_pc, i_instr, in_dec, in_imm};

  always_comb begin
    i_ready = 1'b0;
    if (32'(i_tid) < NTHREADS) begin
      i_ready = (cnt_q[i_tid] != CNT_W'(DEPTH)) & ~flush[i_tid];
    end
  end

  assign push = i_valid & i_ready;

  // Flushed threads drop out of arbitration in the flush cycle itself
  always_comb begin
    for (int t = 0; t < int'(NTHREADS); t++) begin
      avail[t] = (cnt_q[t] != '0) & ~flush[t];
    end
  end

  always_comb begin
    gnt_valid = 1'b0;
    gnt       = '0;
    idx       = 0;
    if (lock_q && avail[lock_tid_q]) begin
      gnt_valid = 1'b1;
      gnt       = lock_tid_q;
    end else begin
      for (int unsigned i = 1; i <= NTHREADS; i++) begin
        idx = (32'(last_q) + i) % NTHREADS;
        if (!gnt_valid && avail[TID_W'(idx)]) begin
          gnt_valid = 1'b1;
          gnt       = TID_W'(idx);
        end
      end
    end
  end

  assign pop = gnt_valid & o_ready;

  always_comb begin
    lock_d     = 1'b0;
    lock_tid_d = lock_tid_q;
    last_d     = last_q;
    if (gnt_valid && !o_ready) begin
      lock_d     = 1'b1;
      lock_tid_d = gnt;
    end
    if (pop) begin
      last_d = gnt;
    end
  end

  always_comb begin
    for (int t = 0; t < int'(NTHREADS); t++) begin
      logic push_t, pop_t;
      push_t = push && (i_tid == TID_W'(t));
      pop_t  = pop && (gnt == TID_W'(t));
      if (flush[t]) begin
        cnt_d[t]  = '0;
        wptr_d[t] = '0;
        rptr_d[t] = '0;
      end else begin
        cnt_d[t]  = cnt_q[t] + CNT_W'(push_t) - CNT_W'(pop_t);
        wptr_d[t] = wptr_q[t] + AW'(push_t);
        rptr_d[t] = rptr_q[t] + AW'(pop_t);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < int'(NTHREADS); t++) begin
        cnt_q[t]  <= '0;
        wptr_q[t] <= '0;
        rptr_q[t] <= '0;
      end
      last_q     <= '0;
      lock_q     <= 1'b0;
      lock_tid_q <= '0;
    end else begin
      for (int t = 0; t < int'(NTHREADS); t++) begin
        cnt_q[t]  <= cnt_d[t];
        wptr_q[t] <= wptr_d[t];
        rptr_q[t] <= rptr_d[t];
      end
      last_q     <= last_d;
      lock_q     <= lock_d;
      lock_tid_q <= lock_tid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[i_tid][wptr_q[i_tid]] <= in_ent;
    end
  end

  assign out_ent = gnt_valid ? mem_q[gnt][rptr_q[gnt]] : '0;
  assign {o_pc, o_instr, out_dec, o_bjp_imm} = out_ent;

  assign o_valid      = gnt_valid;
  assign o_tid        = gnt;
  assign o_rv32       = out_dec.rv32;
  assign o_bjp        = out_dec.bjp;
  assign o_jal        = out_dec.jal;
  assign o_jalr       = out_dec.jalr;
  assign o_bxx        = out_dec.bxx;
  assign o_rs1en      = out_dec.rs1en;
  assign o_rs2en      = out_dec.rs2en;
  assign o_rs1idx     = out_dec.rs1idx;
  assign o_rs2idx     = out_dec.rs2idx;
  assign o_prdt_taken = out_dec.prdt_taken;
  assign o_ttiat      = out_dec.ttiat;
  assign o_ttoat      = out_dec.ttoat;

  always_comb begin
    o_cnt = '0;
    for (int t = 0; t < int'(NTHREADS); t++) begin
      o_cnt[t*CNT_W +: CNT_W] = cnt_q[t];
    end
  end

endmodule

// File: tb/tb_e203_ifu_mt_predec_buf.sv
// Scoreboard bench for the multi-thread pre-decode buffer: expected entries are queued in
// acceptance order and a monitor compares every handshake.
module tb_e203_ifu_mt_predec_buf;

  localparam int unsigned NT = 4;
  localparam int unsigned CW = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic           clk, rst_n;
  logic           i_valid, i_ready;
  logic [31:0]    i_instr, i_pc;
  logic [1:0]     i_tid;
  logic [NT-1:0]  flush;
  logic           o_valid, o_ready;
  logic [1:0]     o_tid;
  logic [31:0]    o_pc, o_instr, o_bjp_imm;
  logic           o_rv32, o_bjp, o_jal, o_jalr, o_bxx, o_rs1en, o_rs2en;
  logic [4:0]     o_rs1idx, o_rs2idx;
  logic           o_prdt_taken, o_ttiat, o_ttoat;
  logic [NT*CW-1:0] o_cnt;

  e203_ifu_mt_predec_buf dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid(i_valid), .i_ready(i_ready), .i_instr(i_instr), .i_pc(i_pc), .i_tid(i_tid),
    .flush(flush),
    .o_valid(o_valid), .o_ready(o_ready), .o_tid(o_tid), .o_pc(o_pc), .o_instr(o_instr),
    .o_rv32(o_rv32), .o_bjp(o_bjp), .o_jal(o_jal), .o_jalr(o_jalr), .o_bxx(o_bxx),
    .o_rs1en(o_rs1en), .o_rs2en(o_rs2en), .o_rs1idx(o_rs1idx), .o_rs2idx(o_rs2idx),
    .o_bjp_imm(o_bjp_imm), .o_prdt_taken(o_prdt_taken), .o_ttiat(o_ttiat),
    .o_ttoat(o_ttoat), .o_cnt(o_cnt)
  );

  typedef struct packed {
    logic [1:0]  tid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        rv32, jal, jalr, bxx, rs1en, rs2en;
    logic [4:0]  rs1, rs2;
    logic [31:0] imm;
    logic        prdt, ttiat, ttoat;
    logic        chk_imm;
    logic [1:0]  chk_idx;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] tid, input logic [31:0] pc, instr,
                              input logic rv32, jal, jalr, bxx, rs1en, rs2en,
                              input logic [4:0] rs1, rs2, input logic [31:0] imm,
                              input logic prdt, ttiat, ttoat, chk_imm,
                              input logic [1:0] chk_idx);
    exp_t e;
    e.tid = tid; e.pc = pc; e.instr = instr;
    e.rv32 = rv32; e.jal = jal; e.jalr = jalr; e.bxx = bxx;
    e.rs1en = rs1en; e.rs2en = rs2en; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm;
    e.prdt = prdt; e.ttiat = ttiat; e.ttoat = ttoat;
    e.chk_imm = chk_imm; e.chk_idx = chk_idx;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && o_valid && o_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_accept actual tid=%0d pc=0x%0h required none", o_tid, o_pc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("acc_tid", o_tid, e.tid);
        chk("acc_pc", o_pc, e.pc);
        chk("acc_instr", o_instr, e.instr);
        chk("acc_rv32", o_rv32, e.rv32);
        chk("acc_bjp", o_bjp, e.jal | e.jalr | e.bxx);
        chk("acc_jal", o_jal, e.jal);
        chk("acc_jalr", o_jalr, e.jalr);
        chk("acc_bxx", o_bxx, e.bxx);
        chk("acc_rs1en", o_rs1en, e.rs1en);
        chk("acc_rs2en", o_rs2en, e.rs2en);
        chk("acc_prdt", o_prdt_taken, e.prdt);
        chk("acc_ttiat", o_ttiat, e.ttiat);
        chk("acc_ttoat", o_ttoat, e.ttoat);
        if (e.chk_idx[1]) chk("acc_rs1idx", o_rs1idx, e.rs1);
        if (e.chk_idx[0]) chk("acc_rs2idx", o_rs2idx, e.rs2);
        if (e.chk_imm) chk("acc_imm", o_bjp_imm, e.imm);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] tid, input logic [31:0] pc, input logic [31:0] instr);
    i_valid = 1'b1; i_tid = tid; i_pc = pc; i_instr = instr;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < max) begin
      tick();
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout actual pending=%0d required pending=0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; i_valid = 1'b0; i_instr = '0; i_pc = '0; i_tid = '0;
    flush = '0; o_ready = 1'b0;
    tick();
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_cnt", o_cnt, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_i_ready", i_ready, 1);
    chk("idle_o_pc_zero", o_pc, 0);

    // JAL x0,-8 on thread 2: visible one cycle after the push edge
    push(2'd2, 32'h100, 32'hFF9F_F06F);
    chk("jal_o_valid", o_valid, 1);
    chk("jal_o_tid", o_tid, 2);
    chk("jal_o_jal", o_jal, 1);
    chk("jal_o_imm", o_bjp_imm, 32'hFFFF_FFF8);
    chk("jal_o_prdt", o_prdt_taken, 1);
    sb_q.push_back(mk(2, 32'h100, 32'hFF9F_F06F, 1, 1, 0, 0, 0, 0, 31, 25, 32'hFFFF_FFF8,
                      1, 0, 0, 1, 2'b11));
    o_ready = 1'b1;
    drain(5);
    o_ready = 1'b0;

    // BEQ forward then backward on thread 0
    push(2'd0, 32'h200, 32'h0020_8863);
    push(2'd0, 32'h204, 32'hFE20_88E3);
    sb_q.push_back(mk(0, 32'h200, 32'h0020_8863, 1, 0, 0, 1, 1, 1, 1, 2, 32'h10,
                      0, 0, 0, 1, 2'b11));
    sb_q.push_back(mk(0, 32'h204, 32'hFE20_88E3, 1, 0, 0, 1, 1, 1, 1, 2, 32'hFFFF_FFF0,
                      1, 0, 0, 1, 2'b11));
    o_ready = 1'b1;
    drain(6);
    o_ready = 1'b0;

    // Fill threads 0, 1, 3; thread 0 pushed first so the lock lands on it
    push(2'd0, 32'h500, NOP);
    push(2'd0, 32'h504, NOP);
    push(2'd1, 32'h300, NOP);
    push(2'd1, 32'h304, NOP);
    #1;
    chk("full_i_ready", i_ready, 0);
    chk("full_cnt1", o_cnt[3:2], 2);
    push(2'd1, 32'h3FC, NOP);
    chk("full_drop_cnt1", o_cnt[3:2], 2);
    i_tid = 2'd3;
    #1;
    chk("tid3_i_ready", i_ready, 1);
    push(2'd3, 32'h400, NOP);
    push(2'd3, 32'h404, NOP);
    chk("cnt_all", o_cnt, {2'd2, 2'd0, 2'd2, 2'd2});
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("hold_tid", o_tid, 0);
      chk("hold_pc", o_pc, 32'h500);
    end
    sb_q.push_back(mk(0, 32'h500, NOP, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b11));
    sb_q.push_back(mk(1, 32'h300, NOP, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b11));
    sb_q.push_back(mk(3, 32'h400, NOP, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b11));
    sb_q.push_back(mk(0, 32'h504, NOP, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b11));
    sb_q.push_back(mk(1, 32'h304, NOP, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b11));
    sb_q.push_back(mk(3, 32'h404, NOP, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b11));
    o_ready = 1'b1;
    drain(10);
    o_ready = 1'b0;
    chk("empty_o_valid", o_valid, 0);
    chk("empty_o_cnt", o_cnt, 0);

    // Flush thread 1 while it holds the lock, with a colliding push
    push(2'd1, 32'h600, NOP);
    push(2'd2, 32'h700, NOP);
    chk("pre_flush_tid", o_tid, 1);
    flush = 4'b0010; i_valid = 1'b1; i_tid = 2'd1; i_pc = 32'h604; i_instr = NOP;
    #1;
    chk("flush_i_ready", i_ready, 0);
    @(posedge clk);
    #1;
    flush = '0; i_valid = 1'b0;
    chk("flush_cnt1", o_cnt[3:2], 0);
    chk("flush_cnt2", o_cnt[5:4], 1);
    chk("flush_o_valid", o_valid, 1);
    chk("flush_o_tid", o_tid, 2);
    sb_q.push_back(mk(2, 32'h700, NOP, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b11));
    o_ready = 1'b1;
    drain(5);

    // RVC and TTIO decode, streamed with the consumer always ready
    sb_q.push_back(mk(3, 32'h800, 32'h0000_E011, 0, 0, 0, 1, 1, 0, 8, 0, 32'h4,
                      0, 0, 0, 1, 2'b11));
    push(2'd3, 32'h800, 32'h0000_E011);
    sb_q.push_back(mk(3, 32'h802, 32'h0000_BFF5, 0, 1, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC,
                      1, 0, 0, 1, 2'b00));
    push(2'd3, 32'h802, 32'h0000_BFF5);
    sb_q.push_back(mk(0, 32'h900, 32'h0000_8082, 0, 0, 1, 0, 1, 0, 1, 0, 0,
                      1, 0, 0, 1, 2'b10));
    push(2'd0, 32'h900, 32'h0000_8082);
    sb_q.push_back(mk(0, 32'h904, 32'h0000_800B, 1, 0, 0, 0, 1, 0, 1, 0, 0,
                      0, 1, 0, 0, 2'b10));
    push(2'd0, 32'h904, 32'h0000_800B);
    sb_q.push_back(mk(0, 32'h908, 32'h0000_900B, 1, 0, 0, 0, 1, 0, 1, 0, 0,
                      0, 0, 1, 0, 2'b10));
    push(2'd0, 32'h908, 32'h0000_900B);
    drain(6);
    o_ready = 1'b0;
    tick();
    chk("final_o_valid", o_valid, 0);
    chk("final_o_imm_zero", o_bjp_imm, 0);
    chk("final_o_pc_zero", o_pc, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
